// File: rtl/wave_output_sequencer.sv
// rtl/wave_output_sequencer.sv - shared R2R DAC owner that sequences waveform generator hand-over
//
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   mode_req     requested mode: 0=off, 1=sawtooth, 2=triangle, 3=square
//   mode_valid   one-cycle strobe qualifying mode_req
//   gen_saw      sawtooth generator code
//   gen_tri      triangle generator code
//   gen_sq       square generator code
//   gen_enable   one-hot generator enable (bit0=saw, bit1=tri, bit2=square)
//   R2R_output   registered code to the R2R DAC
//   active_mode  mode currently driving the output (0 outside RUN)
//   busy         high while draining or settling
//   mode_ack     one-cycle pulse, one clock after an accepted request
//
// Build option: WAVE_SOFT_DRAIN_EN enables the linear ramp-down (DRAIN state).
// Without it a mode change zeroes the output on the next clock.
module wave_output_sequencer #(
    parameter int WIDTH         = 8,
    parameter int DRAIN_DIV     = 1000,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode_req,
    input  logic             mode_valid,
    input  logic [WIDTH-1:0] gen_saw,
    input  logic [WIDTH-1:0] gen_tri,
    input  logic [WIDTH-1:0] gen_sq,
    output logic [2:0]       gen_enable,
    output logic [WIDTH-1:0] R2R_output,
    output logic [1:0]       active_mode,
    output logic             busy,
    output logic             mode_ack
);

    // DRAIN and SETTLE never overlap, so one counter serves as both the
    // drain divider and the settle timer.
    localparam int CNT_MAX = (DRAIN_DIV > SETTLE_CYCLES) ? DRAIN_DIV : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t           r_state, w_state_nx;
    logic [1:0]       r_target, w_target_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    // In DRAIN the output register doubles as the drain register.
    logic [WIDTH-1:0] r_out, w_out_nx;
    logic [2:0]       r_en, w_en_nx;
    logic [1:0]       r_mode, w_mode_nx;
    logic             r_busy, w_busy_nx;
    logic             r_ack, w_ack_nx;
    logic [WIDTH-1:0] w_sel_code;
    logic [2:0]       w_target_onehot;

    always_comb begin
        w_sel_code = '0;
        case (r_mode)
            2'd1:    w_sel_code = gen_saw;
            2'd2:    w_sel_code = gen_tri;
            2'd3:    w_sel_code = gen_sq;
            default: w_sel_code = '0;
        endcase
    end

    always_comb begin
        w_target_onehot = 3'b000;
        case (r_target)
            2'd1:    w_target_onehot = 3'b001;
            2'd2:    w_target_onehot = 3'b010;
            2'd3:    w_target_onehot = 3'b100;
            default: w_target_onehot = 3'b000;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_target_nx = r_target;
        w_cnt_nx    = r_cnt;
        w_out_nx    = '0;
        w_en_nx     = 3'b000;
        w_mode_nx   = 2'd0;
        w_busy_nx   = 1'b0;
        // Every request is accepted in every state.
        w_ack_nx    = mode_valid;

        case (r_state)
            S_OFF: begin
                if (mode_valid && (mode_req != 2'd0)) begin
                    w_target_nx = mode_req;
                    w_cnt_nx    = '0;
                    w_state_nx  = S_SETTLE;
                    w_busy_nx   = 1'b1;
                end
            end

            S_RUN: begin
                w_en_nx   = r_en;
                w_mode_nx = r_mode;
                w_out_nx  = w_sel_code;
                if (mode_valid && (mode_req != r_mode)) begin
                    w_target_nx = mode_req;
                    w_en_nx     = 3'b000;
                    w_mode_nx   = 2'd0;
                    w_cnt_nx    = '0;
`ifdef WAVE_SOFT_DRAIN_EN
                    w_out_nx    = r_out;
                    w_state_nx  = S_DRAIN;
                    w_busy_nx   = 1'b1;
`else
                    w_out_nx    = '0;
                    if (mode_req == 2'd0) begin
                        w_state_nx = S_OFF;
                    end else begin
                        w_state_nx = S_SETTLE;
                        w_busy_nx  = 1'b1;
                    end
`endif
                end
            end

`ifdef WAVE_SOFT_DRAIN_EN
            S_DRAIN: begin
                w_busy_nx = 1'b1;
                w_out_nx  = r_out;
                if (mode_valid) begin
                    w_target_nx = mode_req;
                end
                if (r_out == '0) begin
                    // A request on the exit cycle still decides the destination.
                    w_cnt_nx = '0;
                    if (w_target_nx == 2'd0) begin
                        w_state_nx = S_OFF;
                        w_busy_nx  = 1'b0;
                    end else begin
                        w_state_nx = S_SETTLE;
                    end
                end else if (r_cnt == CNT_W'(DRAIN_DIV - 1)) begin
                    w_out_nx = r_out - 1'b1;
                    w_cnt_nx = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
`endif

            S_SETTLE: begin
                w_busy_nx = 1'b1;
                if (mode_valid) begin
                    w_target_nx = mode_req;
                    w_cnt_nx    = '0;
                    if (mode_req == 2'd0) begin
                        w_state_nx = S_OFF;
                        w_busy_nx  = 1'b0;
                    end
                end else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nx = S_RUN;
                    w_busy_nx  = 1'b0;
                    w_en_nx    = w_target_onehot;
                    w_mode_nx  = r_target;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nx = S_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_OFF;
            r_target <= 2'd0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_en     <= 3'b000;
            r_mode   <= 2'd0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_target <= w_target_nx;
            r_cnt    <= w_cnt_nx;
            r_out    <= w_out_nx;
            r_en     <= w_en_nx;
            r_mode   <= w_mode_nx;
            r_busy   <= w_busy_nx;
            r_ack    <= w_ack_nx;
        end
    end

    assign gen_enable  = r_en;
    assign R2R_output  = r_out;
    assign active_mode = r_mode;
    assign busy        = r_busy;
    assign mode_ack    = r_ack;

endmodule

// File: tb/tb_wave_output_sequencer.sv
// tb/tb_wave_output_sequencer.sv - self-checking bench for wave_output_sequencer
module tb_wave_output_sequencer;

    localparam int WIDTH         = 8;
    localparam int DRAIN_DIV     = 4;
    localparam int SETTLE_CYCLES = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       mode_req;
    logic             mode_valid;
    logic [WIDTH-1:0] gen_saw;
    logic [WIDTH-1:0] gen_tri;
    logic [WIDTH-1:0] gen_sq;
    logic [2:0]       gen_enable;
    logic [WIDTH-1:0] R2R_output;
    logic [1:0]       active_mode;
    logic             busy;
    logic             mode_ack;

    always #5 clk = ~clk;

    wave_output_sequencer #(
        .WIDTH(WIDTH), .DRAIN_DIV(DRAIN_DIV), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .mode_req(mode_req), .mode_valid(mode_valid),
        .gen_saw(gen_saw), .gen_tri(gen_tri), .gen_sq(gen_sq),
        .gen_enable(gen_enable), .R2R_output(R2R_output), .active_mode(active_mode),
        .busy(busy), .mode_ack(mode_ack)
    );

    typedef struct {
        string      name;
        logic       rstn;
        logic       valid;
        logic [1:0] req;
        logic [7:0] saw;
        logic [7:0] tri_c;
        logic [7:0] sq;
        logic [2:0] en;
        logic [7:0] out;
        logic [1:0] mode;
        logic       bsy;
        logic       ack;
    } vec_t;

    vec_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input string name, input logic rstn, input logic valid,
                                input logic [1:0] req, input logic [7:0] saw,
                                input logic [7:0] tri_c, input logic [7:0] sq,
                                input logic [2:0] en, input logic [7:0] out,
                                input logic [1:0] mode, input logic bsy, input logic ack);
        vec_t v;
        v.name = name; v.rstn = rstn; v.valid = valid; v.req = req;
        v.saw = saw; v.tri_c = tri_c; v.sq = sq;
        v.en = en; v.out = out; v.mode = mode; v.bsy = bsy; v.ack = ack;
        return v;
    endfunction

    task automatic check_out();
        vec_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected record for DUT output");
            return;
        end
        e = q.pop_front();
        if ({gen_enable, R2R_output, active_mode, busy, mode_ack} !==
            {e.en, e.out, e.mode, e.bsy, e.ack}) begin
            n_fail++;
            $display("FAIL %s: got en=%b out=%h mode=%0d busy=%b ack=%b, expected en=%b out=%h mode=%0d busy=%b ack=%b",
                     e.name, gen_enable, R2R_output, active_mode, busy, mode_ack,
                     e.en, e.out, e.mode, e.bsy, e.ack);
        end
    endtask

    // Drive one clock of stimulus, queue its expected post-edge outputs, check after the edge.
    task automatic step(input vec_t v);
        reset      = v.rstn;
        mode_valid = v.valid;
        mode_req   = v.req;
        gen_saw    = v.saw;
        gen_tri    = v.tri_c;
        gen_sq     = v.sq;
        q.push_back(v);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    vec_t tbl[13];

    initial begin
        //                 name          rstn v  req saw    tri    sq     en      out    md bsy ack
        tbl[0]  = mk("reset0",        0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 0);
        tbl[1]  = mk("reset1",        0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 0);
        tbl[2]  = mk("off_idle",      1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 0);
        tbl[3]  = mk("off_req0",      1, 1, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 1);
        tbl[4]  = mk("off_req0_after",1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 0);
        tbl[5]  = mk("off_req1",      1, 1, 1, 8'h2A, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 1);
        tbl[6]  = mk("settle1",       1, 0, 0, 8'h2A, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0);
        tbl[7]  = mk("settle2",       1, 0, 0, 8'h2A, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0);
        tbl[8]  = mk("run_saw_entry", 1, 0, 0, 8'h2A, 8'h00, 8'h00, 3'b001, 8'h00, 1, 0, 0);
        tbl[9]  = mk("run_saw_2a",    1, 0, 0, 8'h2A, 8'h00, 8'h00, 3'b001, 8'h2A, 1, 0, 0);
        tbl[10] = mk("run_saw_05",    1, 0, 0, 8'h05, 8'h00, 8'h00, 3'b001, 8'h05, 1, 0, 0);
        tbl[11] = mk("run_same_req",  1, 1, 1, 8'h07, 8'h00, 8'h00, 3'b001, 8'h07, 1, 0, 1);
        tbl[12] = mk("run_saw_05b",   1, 0, 0, 8'h05, 8'h00, 8'h00, 3'b001, 8'h05, 1, 0, 0);

        reset = 1'b0; mode_valid = 1'b0; mode_req = 2'd0;
        gen_saw = '0; gen_tri = '0; gen_sq = '0;

        for (int i = 0; i < 13; i++) step(tbl[i]);

`ifdef WAVE_SOFT_DRAIN_EN
        // Drain 5 -> 0 at one LSB per 4 clocks, then settle, then triangle.
        step(mk("drain_start", 1, 1, 2, 8'h05, 8'h00, 8'h00, 3'b000, 8'h05, 0, 1, 1));
        for (int k = 1; k <= 20; k++)
            step(mk("drain_ramp", 1, 0, 0, 8'h05, 8'h00, 8'h00, 3'b000, 8'(5 - k / 4), 0, 1, 0));
        step(mk("drain_exit",  1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("settle_a1",   1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("settle_a2",   1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("run_tri",     1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b010, 8'h00, 2, 0, 0));
        step(mk("run_tri_03",  1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b010, 8'h03, 2, 0, 0));
        // Two requests during drain, the last (off) wins; square never enabled.
        step(mk("drain_req3",  1, 1, 3, 8'h00, 8'h03, 8'h55, 3'b000, 8'h03, 0, 1, 1));
        step(mk("drain_req0",  1, 1, 0, 8'h00, 8'h03, 8'h55, 3'b000, 8'h03, 0, 1, 1));
        for (int k = 2; k <= 12; k++)
            step(mk("drain_ramp2", 1, 0, 0, 8'h00, 8'h03, 8'h55, 3'b000, 8'(3 - k / 4), 0, 1, 0));
        step(mk("drain_to_off", 1, 0, 0, 8'h00, 8'h03, 8'h55, 3'b000, 8'h00, 0, 0, 0));
        step(mk("off_hold",     1, 0, 0, 8'h00, 8'h03, 8'h55, 3'b000, 8'h00, 0, 0, 0));
`else
        // Hard switch: output and enables drop to 0 on the next clock.
        step(mk("hard_switch", 1, 1, 2, 8'h05, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 1));
        step(mk("settle_a1",   1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("settle_a2",   1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("run_tri",     1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b010, 8'h00, 2, 0, 0));
        step(mk("run_tri_03",  1, 0, 0, 8'h00, 8'h03, 8'h00, 3'b010, 8'h03, 2, 0, 0));
        step(mk("switch_req3", 1, 1, 3, 8'h00, 8'h03, 8'h55, 3'b000, 8'h00, 0, 1, 1));
        step(mk("settle_req0", 1, 1, 0, 8'h00, 8'h03, 8'h55, 3'b000, 8'h00, 0, 0, 1));
        step(mk("off_hold",    1, 0, 0, 8'h00, 8'h03, 8'h55, 3'b000, 8'h00, 0, 0, 0));
`endif

        // Square mode, same-mode request is ack only.
        step(mk("off_req3",    1, 1, 3, 8'h00, 8'h00, 8'h80, 3'b000, 8'h00, 0, 1, 1));
        step(mk("settle_b1",   1, 0, 0, 8'h00, 8'h00, 8'h80, 3'b000, 8'h00, 0, 1, 0));
        step(mk("settle_b2",   1, 0, 0, 8'h00, 8'h00, 8'h80, 3'b000, 8'h00, 0, 1, 0));
        step(mk("run_sq",      1, 0, 0, 8'h00, 8'h00, 8'h80, 3'b100, 8'h00, 3, 0, 0));
        step(mk("run_sq_80",   1, 0, 0, 8'h00, 8'h00, 8'h80, 3'b100, 8'h80, 3, 0, 0));
        step(mk("run_sq_same", 1, 1, 3, 8'h00, 8'h00, 8'h80, 3'b100, 8'h80, 3, 0, 1));
        step(mk("run_sq_hold", 1, 0, 0, 8'h00, 8'h00, 8'h80, 3'b100, 8'h80, 3, 0, 0));

`ifdef WAVE_SOFT_DRAIN_EN
        step(mk("drain80",     1, 1, 1, 8'h00, 8'h00, 8'h80, 3'b000, 8'h80, 0, 1, 1));
        step(mk("drain80_hold",1, 0, 0, 8'h00, 8'h00, 8'h80, 3'b000, 8'h80, 0, 1, 0));
`else
        step(mk("hard80",      1, 1, 1, 8'h00, 8'h00, 8'h80, 3'b000, 8'h00, 0, 1, 1));
        step(mk("hard80_settle",1, 0, 0, 8'h00, 8'h00, 8'h80, 3'b000, 8'h00, 0, 1, 0));
`endif
        // Reset with a simultaneous strobe: reset wins, no ack.
        step(mk("reset_mid",   0, 1, 2, 8'h00, 8'h00, 8'h80, 3'b000, 8'h00, 0, 0, 0));
        step(mk("post_reset",  1, 0, 0, 8'h00, 8'h00, 8'h80, 3'b000, 8'h00, 0, 0, 0));

        // A request in SETTLE restarts the settle count.
        step(mk("off_req1b",   1, 1, 1, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 1));
        step(mk("settle_req2", 1, 1, 2, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 1));
        step(mk("restart_c1",  1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("restart_c2",  1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("run_tri_b",   1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b010, 8'h00, 2, 0, 0));

        // Mode change from output 0.
        step(mk("switch_from0",1, 1, 1, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 1));
`ifdef WAVE_SOFT_DRAIN_EN
        step(mk("drain0_exit", 1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0));
`endif
        step(mk("settle_c1",   1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("settle_c2",   1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("run_saw_c",   1, 0, 0, 8'h11, 8'h00, 8'h00, 3'b001, 8'h00, 1, 0, 0));
        step(mk("run_saw_11",  1, 0, 0, 8'h11, 8'h00, 8'h00, 3'b001, 8'h11, 1, 0, 0));

        // Reset mid-SETTLE.
        step(mk("to_settle",   1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b001, 8'h00, 1, 0, 0));
        step(mk("rq_off_run",  1, 1, 2, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 1));
`ifdef WAVE_SOFT_DRAIN_EN
        step(mk("drain0_exit2",1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0));
`endif
        step(mk("settle_mid",  1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 0));
        step(mk("reset_settle",0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 0));
        step(mk("post_reset2", 1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 0));

        // Request for off while settling returns to OFF next cycle.
        step(mk("off_req2",    1, 1, 2, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 1, 1));
        step(mk("settle_off",  1, 1, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 1));
        step(mk("off_final",   1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
